ps2_rx_fifo: RTL and testbench

- PS/2 device-to-host receiver with an internal byte FIFO; directly upstream of kbd_ctrl.
- Presents the data/ready/nextdata_n/overflow handshake that kbd_ctrl consumes.
- Adds input synchronisation, frame checking (start/parity/stop), a stall timeout, and an explicit error pulse.

---
 rtl/ps2_pkg.sv | 7 +
 rtl/ps2_byte_fifo.sv | 39 +++
 rtl/ps2_rx_fifo.sv | 114 +++++++++++
 tb/tb_ps2_rx_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver state encoding, frame size and scancode constants.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: synchronous byte FIFO with sticky overflow that clears on the next accepted pop.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       overflow_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic ovf_q, do_pop, do_push;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign overflow_o = ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
      ovf_q <= do_pop ? 1'b0 : (push_i & full_o) ? 1'b1 : ovf_q;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver feeding a byte FIFO.
// Define PS2_RX_PARITY_CHECK_EN to reject frames with bad parity or stop bit.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic clk_prev_q;
  rx_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [TW-1:0] to_q, to_d;
  logic push_q, push_d, err_q, err_d;
  logic fall, bit_s, timeout, frame_ok, empty, full;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end
  assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_s = dat_sync_q[SYNC_STAGES-1];
  assign timeout = (state_q != IDLE) && !fall && (to_q == TW'(TIMEOUT_CYCLES - 1));
`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) par_q <= 1'b0;
    else if (fall && state_q == PARITY) par_q <= bit_s;
  assign frame_ok = (^{shift_q, par_q}) & bit_s;
`else
  assign frame_ok = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    push_d = 1'b0;
    err_d = 1'b0;
    to_d = (state_q == IDLE || fall) ? '0 : to_q + TW'(1);
    if (timeout) begin
      state_d = IDLE;
      shift_d = '0;
      err_d = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d = bit_s ? IDLE : DATA;
          cnt_d = '0;
        end
        DATA: begin
          shift_d = {bit_s, shift_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          state_d = (cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: state_d = STOP;
        STOP: begin
          state_d = IDLE;
          push_d = frame_ok;
          err_d = ~frame_ok;
        end
      endcase
    end
  end
  // shift_q is stable for several ps2 bit times after STOP, so the delayed push reads it directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      to_q <= '0;
      push_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      to_q <= to_d;
      push_q <= push_d;
      err_q <= err_d;
    end
  end
  ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_q),
    .din_i     (shift_q),
    .pop_i     (~nextdata_n),
    .head_o    (data),
    .empty_o   (empty),
    .full_o    (full),
    .overflow_o(overflow)
  );
  assign ready = ~empty;
  assign frame_err = err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: table vectors, hand sequences and random traffic checked against a queue model.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int SYNC = 2;
  localparam int TO = 300;
  localparam int H = 6;
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, nextdata_n = 1'b1;
  logic [7:0] data;
  logic ready, overflow, frame_err;
  int checks = 0, errors = 0;
  int err_hi = 0, err_rise = 0, exp_err = 0;
  logic err_prev = 1'b0;
  logic [7:0] q[$];
  bit ovf = 1'b0;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data), .ready(ready), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_hi++;
    if (frame_err && !err_prev) err_rise++;
    err_prev = frame_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name);
    chk({name, " ready"}, 32'(ready), 32'(q.size() != 0));
    chk({name, " data"}, 32'(data), 32'(q.size() != 0 ? q[0] : 8'h00));
    chk({name, " overflow"}, 32'(overflow), 32'(ovf));
  endtask

  task automatic check_err(input string name);
    chk({name, " frame_err cycles"}, err_hi, exp_err);
    chk({name, " frame_err pulses"}, err_rise, exp_err);
  endtask

  task automatic clk_bit(input logic v);
    ps2_data = v;
    tick(H);
    ps2_clk = 1'b0;
    tick(H);
    ps2_clk = 1'b1;
  endtask

  // start, 8 data bits LSB first, parity (odd, optionally inverted)
  task automatic head10(input logic [7:0] b, input bit pflip);
    clk_bit(1'b0);
    for (int i = 0; i < 8; i++) clk_bit(b[i]);
    clk_bit(~^b ^ pflip);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit pflip, input bit stp);
    if (!CHK || (!pflip && stp)) begin
      if (q.size() < DEPTH) q.push_back(b);
      else ovf = 1'b1;
    end else exp_err++;
  endtask

  task automatic send(input logic [7:0] b, input bit pflip, input bit stp);
    head10(b, pflip);
    clk_bit(stp);
    ps2_data = 1'b1;
    tick(8);
    model_frame(b, pflip, stp);
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    tick(1);
    nextdata_n = 1'b1;
    if (q.size() != 0) begin
      void'(q.pop_front());
      ovf = 1'b0;
    end
  endtask

  task automatic drain();
    while (q.size() != 0) pop_one();
  endtask

  typedef struct {
    bit is_pop;
    logic [7:0] b;
    logic exp_ready;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b0, 8'h1C, 1'b1, 8'h1C};
    tbl[1] = '{1'b1, 8'h00, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'hF0, 1'b1, 8'hF0};
    tbl[3] = '{1'b0, 8'h1C, 1'b1, 8'hF0};
    tbl[4] = '{1'b1, 8'h00, 1'b1, 8'h1C};
    tbl[5] = '{1'b1, 8'h00, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 8'h00, 1'b0, 8'h00};

    tick(3);
    chk("reset ready", 32'(ready), 0);
    chk("reset data", 32'(data), 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset frame_err", 32'(frame_err), 0);
    rst = 1'b0;
    tick(2);

    foreach (tbl[i]) begin
      if (tbl[i].is_pop) pop_one();
      else send(tbl[i].b, 1'b0, 1'b1);
      chk($sformatf("vec%0d ready", i), 32'(ready), 32'(tbl[i].exp_ready));
      chk($sformatf("vec%0d data", i), 32'(data), 32'(tbl[i].exp_data));
      chk($sformatf("vec%0d overflow", i), 32'(overflow), 0);
    end

    // exact latency, with a pop on the push cycle while empty (pop must be ignored)
    head10(8'h1C, 1'b0);
    ps2_data = 1'b1;
    tick(H);
    ps2_clk = 1'b0;
    tick(SYNC + 1);
    chk("latency early ready", 32'(ready), 0);
    nextdata_n = 1'b0;
    tick(1);
    nextdata_n = 1'b1;
    chk("latency ready", 32'(ready), 1);
    chk("latency data", 32'(data), 32'h1C);
    tick(H);
    ps2_clk = 1'b1;
    tick(8);
    model_frame(8'h1C, 1'b0, 1'b1);
    check_state("empty push+pop");
    drain();

    for (int i = 1; i <= 9; i++) begin
      send(8'(i), 1'b0, 1'b1);
      if (i == 8) chk("eight queued overflow", 32'(overflow), 0);
    end
    chk("nine queued overflow", 32'(overflow), 1);
    check_state("overflow");
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("overflow pop%0d data", i), 32'(data), 32'(i));
      pop_one();
      check_state($sformatf("overflow pop%0d", i));
    end

    // full FIFO with a pop landing on the push cycle: both accepted
    for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i), 1'b0, 1'b1);
    head10(8'h77, 1'b0);
    ps2_data = 1'b1;
    tick(H);
    ps2_clk = 1'b0;
    tick(SYNC + 1);
    nextdata_n = 1'b0;
    tick(1);
    nextdata_n = 1'b1;
    void'(q.pop_front());
    q.push_back(8'h77);
    check_state("full push+pop");
    tick(H);
    ps2_clk = 1'b1;
    tick(8);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("full push+pop drain%0d", i), 32'(data), 32'(q[0]));
      pop_one();
    end
    check_state("full push+pop empty");

    send(8'h1C, 1'b1, 1'b1);
    check_state("bad parity");
    check_err("bad parity");
    drain();

    clk_bit(1'b0);
    for (int i = 0; i < 4; i++) clk_bit(i[0]);
    ps2_data = 1'b1;
    tick(TO + 20);
    exp_err++;
    check_err("timeout");
    check_state("timeout");
    send(8'h32, 1'b0, 1'b1);
    chk("after timeout data", 32'(data), 32'h32);
    check_state("after timeout");
    drain();

    for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 1'b0, 1'b1);
    clk_bit(1'b0);
    clk_bit(1'b1);
    ps2_data = 1'b0;
    tick(H);
    ps2_clk = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    chk("async reset ready", 32'(ready), 0);
    chk("async reset data", 32'(data), 0);
    chk("async reset overflow", 32'(overflow), 0);
    q.delete();
    ovf = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    send(8'h29, 1'b0, 1'b1);
    chk("post reset data", 32'(data), 32'h29);
    pop_one();
    chk("post reset single entry", 32'(ready), 0);
    check_err("post reset");

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 4);
      if (r <= 1) send(8'($urandom), 1'b0, 1'b1);
      else if (r == 2) send(8'($urandom), 1'($urandom), 1'($urandom));
      else pop_one();
      check_state($sformatf("rand%0d", n));
    end
    check_err("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
